// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared widths, control bundle and MEM-stage FSM states for the MIPS pipeline.
package mips_pipe_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    typedef struct packed {
        logic memread;
        logic memwrite;
        logic regwrite;
        logic memtoreg;
    } mem_ctrl_t;
    typedef enum logic {IDLE, WAIT} mem_state_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: EX/MEM inputs and MEM/WB outputs of the memory stage.
interface mem_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              valid_in;
    logic [DATA_W-1:0] aluout_in;
    logic [DATA_W-1:0] writedata_in;
    logic [REG_W-1:0]  writereg_in;
    logic              memread_in;
    logic              memwrite_in;
    logic              regwrite_in;
    logic              memtoreg_in;
    logic              flush_in;
    logic              stall_out;
    logic              valid_out;
    logic [DATA_W-1:0] aluout_out;
    logic [DATA_W-1:0] readdata_out;
    logic [REG_W-1:0]  writereg_out;
    logic              regwrite_out;
    logic              memtoreg_out;
    logic              misalign_out;
    modport master (
        output valid_in, aluout_in, writedata_in, writereg_in, memread_in, memwrite_in,
               regwrite_in, memtoreg_in, flush_in,
        input  stall_out, valid_out, aluout_out, readdata_out, writereg_out, regwrite_out,
               memtoreg_out, misalign_out
    );
    modport slave (
        input  valid_in, aluout_in, writedata_in, writereg_in, memread_in, memwrite_in,
               regwrite_in, memtoreg_in, flush_in,
        output stall_out, valid_out, aluout_out, readdata_out, writereg_out, regwrite_out,
               memtoreg_out, misalign_out
    );
endinterface

// File: rtl/dmem_sp.sv
// dmem_sp: single-port word RAM, synchronous write, asynchronous read, no reset.
module dmem_sp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MIPS MEM stage with wait-stated data RAM and the MEM/WB pipeline register.
module mem_wb_stage #(
    parameter int DATA_W  = mips_pipe_pkg::DATA_W,
    parameter int REG_W   = mips_pipe_pkg::REG_W,
    parameter int DEPTH   = 64,
    parameter int MEM_LAT = 2
) (
    input logic          clk,
    input logic          reset,
    mem_wb_stage_if.slave bus
);
    import mips_pipe_pkg::*;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
    mem_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;
    logic [DATA_W-1:0] r_aluout;
    logic [DATA_W-1:0] r_rdata;
    logic [REG_W-1:0]  r_wreg;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic              r_misalign;
    mem_ctrl_t         w_ctrl;
    logic              w_aligned;
    logic              w_mem_op;
    logic              w_done;
    logic              w_fire;
    logic              w_load;
    logic              w_we;
    logic              w_kill;
    logic [DATA_W-1:0] w_rdata;
    assign w_ctrl = '{memread: bus.memread_in, memwrite: bus.memwrite_in,
                      regwrite: bus.regwrite_in, memtoreg: bus.memtoreg_in};
    // w_done marks the edge that retires the instruction; otherwise a bubble is registered
    always_comb begin
        w_kill    = !reset || bus.flush_in;
        w_aligned = bus.aluout_in[1:0] == 2'b00;
        w_mem_op  = bus.valid_in && (w_ctrl.memread || w_ctrl.memwrite) && w_aligned;
        w_done    = (r_state == WAIT) ? (r_cnt == '0) : (!w_mem_op || MEM_LAT == 0);
        w_fire    = w_done && bus.valid_in;
        w_load    = w_mem_op && w_ctrl.memread && !w_ctrl.memwrite;
        w_we      = !w_kill && w_done && w_mem_op && w_ctrl.memwrite;
    end
    assign bus.stall_out = !w_kill && !w_done;
    dmem_sp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dmem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (bus.aluout_in[2 +: IDX_W]),
        .i_wdata (bus.writedata_in),
        .o_rdata (w_rdata)
    );
    always_ff @(posedge clk) begin
        if (w_kill) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_aluout   <= '0;
            r_rdata    <= '0;
            r_wreg     <= '0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_done ? IDLE : WAIT;
            r_cnt      <= w_done ? '0 : (r_state == IDLE) ? CNT_INIT : r_cnt - 1'b1;
            r_valid    <= w_fire;
            r_aluout   <= w_fire ? bus.aluout_in : '0;
            r_rdata    <= (w_fire && w_load) ? w_rdata : '0;
            r_wreg     <= w_fire ? bus.writereg_in : '0;
            r_regwrite <= w_fire && w_ctrl.regwrite;
            r_memtoreg <= w_fire && w_ctrl.memtoreg;
            r_misalign <= w_fire && (w_ctrl.memread || w_ctrl.memwrite) && !w_aligned;
        end
    end
    assign bus.valid_out    = r_valid;
    assign bus.aluout_out   = r_aluout;
    assign bus.readdata_out = r_rdata;
    assign bus.writereg_out = r_wreg;
    assign bus.regwrite_out = r_regwrite;
    assign bus.memtoreg_out = r_memtoreg;
    assign bus.misalign_out = r_misalign;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vectors for mem_wb_stage with DEPTH=64, MEM_LAT=2.
module tb_mem_wb_stage;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;
    logic [31:0] r_got;
    mem_wb_stage_if #(.DATA_W(32), .REG_W(5)) bus ();
    mem_wb_stage #(.DATA_W(32), .REG_W(5), .DEPTH(64), .MEM_LAT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr, input logic mr, input logic mw,
                         input logic rw, input logic mt);
        bus.valid_in     = v;
        bus.aluout_in    = alu;
        bus.writedata_in = wd;
        bus.writereg_in  = wr;
        bus.memread_in   = mr;
        bus.memwrite_in  = mw;
        bus.regwrite_in  = rw;
        bus.memtoreg_in  = mt;
        #1;
    endtask
    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
        drive(1'b1, addr, data, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        idle();
    endtask
    task automatic do_load(input logic [31:0] addr, output logic [31:0] got);
        drive(1'b1, addr, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) tick();
        got = bus.readdata_out;
        idle();
    endtask
    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b0;
        bus.flush_in = 1'b0;
        idle();
        repeat (2) tick();
        check("rst_valid", {31'b0, bus.valid_out}, 32'h0);
        check("rst_aluout", bus.aluout_out, 32'h0);
        check("rst_regwrite", {31'b0, bus.regwrite_out}, 32'h0);
        check("rst_stall", {31'b0, bus.stall_out}, 32'h0);
        reset = 1'b1;
        // 1: plain ALU op, latency 1
        drive(1'b1, 32'hDEADBEEF, 32'h0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0);
        check("alu_stall", {31'b0, bus.stall_out}, 32'h0);
        tick();
        check("alu_valid", {31'b0, bus.valid_out}, 32'h1);
        check("alu_aluout", bus.aluout_out, 32'hDEADBEEF);
        check("alu_wreg", {27'b0, bus.writereg_out}, 32'd31);
        check("alu_regwrite", {31'b0, bus.regwrite_out}, 32'h1);
        check("alu_rdata", bus.readdata_out, 32'h0);
        idle();
        tick();
        check("bubble_valid", {31'b0, bus.valid_out}, 32'h0);
        check("bubble_regwrite", {31'b0, bus.regwrite_out}, 32'h0);
        // 2: store with two wait cycles, then load back
        drive(1'b1, 32'h10, 32'hCAFEBABE, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("st_stall0", {31'b0, bus.stall_out}, 32'h1);
        tick();
        check("st_valid1", {31'b0, bus.valid_out}, 32'h0);
        check("st_stall1", {31'b0, bus.stall_out}, 32'h1);
        tick();
        check("st_valid2", {31'b0, bus.valid_out}, 32'h0);
        check("st_stall2", {31'b0, bus.stall_out}, 32'h0);
        tick();
        check("st_valid3", {31'b0, bus.valid_out}, 32'h1);
        check("st_aluout", bus.aluout_out, 32'h10);
        check("st_regwrite", {31'b0, bus.regwrite_out}, 32'h0);
        do_load(32'h10, r_got);
        check("ld_data", r_got, 32'hCAFEBABE);
        // 3: misaligned accesses pass through without stalling or writing
        do_store(32'h20, 32'hA5A5A5A5);
        drive(1'b1, 32'h12, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        check("mis_ld_stall", {31'b0, bus.stall_out}, 32'h0);
        tick();
        check("mis_ld_flag", {31'b0, bus.misalign_out}, 32'h1);
        check("mis_ld_rdata", bus.readdata_out, 32'h0);
        check("mis_ld_valid", {31'b0, bus.valid_out}, 32'h1);
        drive(1'b1, 32'h22, 32'h87654321, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("mis_st_stall", {31'b0, bus.stall_out}, 32'h0);
        tick();
        check("mis_st_flag", {31'b0, bus.misalign_out}, 32'h1);
        check("mis_st_aluout", bus.aluout_out, 32'h22);
        idle();
        do_load(32'h20, r_got);
        check("mis_st_ram", r_got, 32'hA5A5A5A5);
        // 4: reset on the completing edge drops the pending store
        do_store(32'h20, 32'h87654321);
        drive(1'b1, 32'h20, 32'h12345678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rstw_valid", {31'b0, bus.valid_out}, 32'h0);
        check("rstw_aluout", bus.aluout_out, 32'h0);
        reset = 1'b1;
        idle();
        do_load(32'h20, r_got);
        check("rstw_ram", r_got, 32'h87654321);
        // 5: flush during WAIT aborts the store and drops stall at once
        drive(1'b1, 32'h20, 32'h12345678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("fl_stall_pre", {31'b0, bus.stall_out}, 32'h1);
        bus.flush_in = 1'b1;
        #1;
        check("fl_stall", {31'b0, bus.stall_out}, 32'h0);
        tick();
        bus.flush_in = 1'b0;
        check("fl_valid", {31'b0, bus.valid_out}, 32'h0);
        idle();
        do_load(32'h20, r_got);
        check("fl_ram", r_got, 32'h87654321);
        // 6: address index wraps modulo DEPTH
        do_store(32'h100, 32'h0BADF00D);
        do_load(32'h0, r_got);
        check("wrap_data", r_got, 32'h0BADF00D);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
